// File: rtl/ms_timer_ctrl.sv
// Millisecond countdown timer controller driven by the 1 kHz divider tick.
// Handles start/pause/resume/clear/load commands, optional auto-reload, and expiry signalling.
module ms_timer_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_ms,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         auto_reload,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         running,
  output logic         done,
  output logic         expire
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] preset_reg, preset_next;
  logic [W-1:0] remaining_next;
  logic         tick_d_reg;
  logic         tick_rise;
  logic         expire_next;

  assign tick_rise = tick_ms & ~tick_d_reg;

  always_comb begin
    state_next     = state_reg;
    preset_next    = preset_reg;
    remaining_next = remaining;
    expire_next    = 1'b0;

    if (clear) begin
      state_next     = IDLE;
      remaining_next = preset_reg;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load) begin
            preset_next    = load_val;
            remaining_next = load_val;
          end else if (start && remaining != '0) begin
            state_next = RUN;
          end
        end
        RUN: begin
          // The tick is applied regardless of commands; an expiry overrides pause.
          if (tick_rise && remaining != '0) begin
            if (remaining > W'(1)) begin
              remaining_next = remaining - W'(1);
            end else if (auto_reload && preset_reg != '0) begin
              remaining_next = preset_reg;
              expire_next    = 1'b1;
            end else begin
              remaining_next = '0;
              state_next     = DONE;
              expire_next    = 1'b1;
            end
          end
          if (pause && !load && !start && !expire_next) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (load) begin
            preset_next    = load_val;
            remaining_next = load_val;
            if (load_val == '0) begin
              state_next = IDLE;
            end
          end else if (start) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (load) begin
            preset_next    = load_val;
            remaining_next = load_val;
            state_next     = IDLE;
          end else if (start) begin
            remaining_next = preset_reg;
            if (preset_reg != '0) begin
              state_next = RUN;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Status flags decode the next state so they move on the same edge as state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      preset_reg <= '0;
      remaining  <= '0;
      tick_d_reg <= 1'b0;
      busy       <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      expire     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      preset_reg <= preset_next;
      remaining  <= remaining_next;
      tick_d_reg <= tick_ms;
      busy       <= (state_next == RUN) || (state_next == PAUSE);
      running    <= (state_next == RUN);
      done       <= (state_next == DONE);
      expire     <= expire_next;
    end
  end

endmodule

// File: tb/tb_ms_timer_ctrl.sv
// Scoreboard bench for ms_timer_ctrl: directed scenarios followed by random commands and ticks,
// checked every cycle against a behavioural model of the timer.
module tb_ms_timer_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tick_ms = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] remaining;
  logic         busy, running, done, expire;

  ms_timer_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .start(start), .pause(pause), .clear(clear),
    .remaining(remaining), .busy(busy), .running(running), .done(done), .expire(expire)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] rem;
    logic         busy;
    logic         running;
    logic         done;
    logic         expire;
  } obs_t;

  obs_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   expire_seen = 0;
  int   done_seen = 0;
  int   cyc = 0;

  // Behavioural model: what the timer should be doing, in plain terms.
  string  m_phase = "IDLE";
  int     m_preset = 0;
  int     m_rem = 0;
  bit     m_tick_prev = 0;
  bit     m_expire = 0;

  task automatic model_step(input bit r, c, l, input int lv, input bit s, p, t, ar);
    bit rise;
    obs_t e;
    rise     = t && !m_tick_prev;
    m_expire = 0;
    if (r) begin
      m_phase = "IDLE"; m_preset = 0; m_rem = 0; m_tick_prev = 0;
    end else begin
      m_tick_prev = t;
      if (c) begin
        m_phase = "IDLE";
        m_rem   = m_preset;
      end else if (m_phase == "IDLE") begin
        if (l) begin m_preset = lv; m_rem = lv; end
        else if (s && m_rem > 0) m_phase = "RUN";
      end else if (m_phase == "RUN") begin
        if (rise && m_rem > 0) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_expire = 1;
            if (ar && m_preset > 0) m_rem = m_preset;
            else m_phase = "DONE";
          end
        end
        if (p && !l && !s && !m_expire) m_phase = "PAUSE";
      end else if (m_phase == "PAUSE") begin
        if (l) begin
          m_preset = lv; m_rem = lv;
          if (lv == 0) m_phase = "IDLE";
        end else if (s) m_phase = "RUN";
      end else begin
        if (l) begin m_preset = lv; m_rem = lv; m_phase = "IDLE"; end
        else if (s) begin
          m_rem = m_preset;
          if (m_preset > 0) m_phase = "RUN";
        end
      end
    end
    e.rem     = W'(m_rem);
    e.busy    = (m_phase == "RUN") || (m_phase == "PAUSE");
    e.running = (m_phase == "RUN");
    e.done    = (m_phase == "DONE");
    e.expire  = m_expire;
    q.push_back(e);
  endtask

  // One clock of stimulus: drive away from the sampling edge and record the expected result.
  task automatic drive(input bit r, c, l, input int lv, input bit s, p, t);
    @(negedge clk);
    rst = r; clear = c; load = l; load_val = W'(lv); start = s; pause = p; tick_ms = t;
    model_step(r, c, l, lv, s, p, t, auto_reload);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queued expectation.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{rem: remaining, busy: busy, running: running, done: done, expire: expire};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cyc%0d outputs: got rem=%0d busy=%b run=%b done=%b exp=%b, expected rem=%0d busy=%b run=%b done=%b exp=%b",
                   cyc, a.rem, a.busy, a.running, a.done, a.expire,
                   e.rem, e.busy, e.running, e.done, e.expire);
        end else begin
          $display("cyc%0d rem=%0d busy=%b run=%b done=%b exp=%b", cyc, a.rem, a.busy, a.running, a.done, a.expire);
        end
        if (expire === 1'b1) expire_seen++;
        if (done === 1'b1) done_seen++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, k;
    bit c, l, s, p, t;
    int lv;

    // Reset, then a 5 ms countdown.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    e0 = expire_seen;
    ticks(5);
    idle(2);
    check_int("basic_expire_count", expire_seen - e0, 1);

    // Pause and resume with a 10 ms preset.
    drive(0, 0, 1, 10, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    ticks(3);
    drive(0, 0, 0, 0, 0, 1, 0);
    ticks(4);
    drive(0, 0, 0, 0, 1, 0, 0);
    e0 = expire_seen;
    ticks(6);
    check_int("resume_no_early_expire", expire_seen - e0, 0);
    ticks(1);
    idle(1);
    check_int("resume_expire_on_last", expire_seen - e0, 1);

    // A tick coincident with pause at remaining=1 still expires.
    drive(0, 0, 1, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    ticks(1);
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check_int("pause_tick_done", int'(done), 1);

    // Auto-reload with a 3 ms preset.
    drive(0, 0, 1, 3, 0, 0, 0);
    @(negedge clk); auto_reload = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0);
    e0 = expire_seen; d0 = done_seen;
    ticks(9);
    idle(1);
    check_int("reload_expire_count", expire_seen - e0, 3);
    check_int("reload_done_never", done_seen - d0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    @(negedge clk); auto_reload = 1'b0;

    // clear beats load and start; a zero preset cannot start.
    drive(0, 0, 1, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    ticks(2);
    drive(0, 1, 1, 9, 1, 0, 0);
    idle(1);
    check_int("clear_priority_rem", int'(remaining), 6);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    check_int("zero_start_busy", int'(busy), 0);

    // A long tick level counts once.
    drive(0, 0, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check_int("held_tick_once", int'(remaining), 4);

    // Reset mid-run loses everything.
    drive(0, 0, 1, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    ticks(2);
    drive(1, 0, 0, 0, 0, 0, 0);
    ticks(3);
    check_int("reset_midrun_rem", int'(remaining), 0);

    // Random commands against a free-running tick pattern.
    k = 0;
    for (int i = 0; i < 3000; i++) begin
      t  = (k % 6) < 2;
      k  = k + 1 + ((i % 97) == 0 ? 1 : 0);
      c  = ($urandom_range(0, 99) < 2);
      lv = $urandom_range(0, 12);
      l = 0; s = 0; p = 0;
      case ($urandom_range(0, 99))
        0, 1, 2, 3:          l = 1;
        10, 11, 12, 13, 14, 15: s = 1;
        20, 21, 22, 23:      p = 1;
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk); auto_reload = ~auto_reload;
      end
      drive(($urandom_range(0, 999) < 3), c, l, lv, s, p, t);
    end
    idle(3);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ms_timer_ctrl.md
# ms_timer_ctrl

- Countdown timer controller that consumes the 1 kHz tick from the millisecond clock divider.
- Sequences a programmable millisecond countdown through start, pause, resume, clear and optional auto-reload.
- Signals expiry with a level and a one-cycle pulse.
- Sits between the divider and the user-facing logic: push-buttons and the 7-segment display driver.

## Interface

Parameters:
- W, 16, width of the preset and remaining-count registers, in ms.

Ports:
- clk  input  1  system clock (CLOCK_50 domain); the only clock.
- rst  input  1  synchronous, active-high reset.
- tick_ms  input  1  1 kHz tick from the divider, synchronous to clk; the rising edge is counted.
- load  input  1  pulse; capture load_val as the preset.
- load_val  input  W  preset value in ms.
- auto_reload  input  1  level; on expiry, reload the preset and keep running.
- start  input  1  pulse; start, or resume from pause.
- pause  input  1  pulse; freeze the countdown.
- clear  input  1  pulse; abort and return to IDLE with the preset restored.
- remaining  output  W  current remaining ms.
- busy  output  1  high in RUN and PAUSE.
- running  output  1  high in RUN only.
- done  output  1  level, high in DONE.
- expire  output  1  one-cycle pulse on every expiry, including auto-reload expiries.

## Operation

- Internal registers:
  - preset[W-1:0];
  - tick_d, the previous tick_ms, used for rising-edge detect: tick_rise = tick_ms & ~tick_d;
  - a 2-bit state: IDLE, RUN, PAUSE, DONE.
- All outputs are registered.
- Reset values: state=IDLE, preset=0, remaining=0, tick_d=0, busy=0, running=0, done=0, expire=0.
- expire defaults to 0 every cycle unless it is set below.
- Command priority in every state: clear > load > start > pause. Lower-priority commands in the same cycle are ignored, except that a tick is still applied as stated below.
- clear (any state): state<=IDLE; remaining<=preset.
- IDLE:
  - load: preset<=load_val and remaining<=load_val.
  - start with remaining!=0 -> RUN.
  - start with remaining==0 is ignored.
  - tick_rise is ignored.
- RUN, on tick_rise:
  - If remaining>1: remaining<=remaining-1.
  - If remaining==1 and auto_reload==0: remaining<=0, state<=DONE, expire<=1.
  - If remaining==1 and auto_reload==1: remaining<=preset, stay in RUN, expire<=1.
  - If preset==0 in the auto_reload case: remaining<=0, go to DONE instead.
- RUN commands:
  - pause -> PAUSE. A tick_rise in the same cycle is still applied, including the expiry transition; expiry wins over pause.
  - load is ignored.
  - start is ignored.
- PAUSE:
  - tick_rise is ignored.
  - start -> RUN.
  - load: preset<=load_val and remaining<=load_val; stay in PAUSE. If load_val==0, go to IDLE.
- DONE:
  - remaining holds 0.
  - start: remaining<=preset, -> RUN if preset!=0.
  - load: as in IDLE, and state<=IDLE.
- Arithmetic: W-bit unsigned. remaining never decrements below 0 and never wraps.
- Output decode: busy=(RUN|PAUSE), running=RUN, done=DONE. These are registered from the next state, so they change on the same edge as state.

## Timing

- Command latency: 1 cycle. A command sampled on edge k is reflected in state and outputs after edge k.
- Tick latency: a rising tick_ms at edge k updates remaining after edge k.
- A tick_ms held high for N cycles counts once; it must fall and rise again to count again.
- expire is high for exactly one clk cycle per expiry. Back-to-back auto-reload expiries are at least 1 ms of ticks apart.
- A preset of N ms expires on the Nth tick_rise after start.
- Wall-clock latency from start to expiry is between N-1 ms and N ms, because tick phase is not aligned to start.
- rst mid-operation: every register returns to its reset value on the next edge; the preset is lost.
- Commands do not need to be one cycle wide. A held level re-issues the command each cycle, and the result must be idempotent, e.g. start held in RUN has no effect.

## Test plan

- Reset and load: assert rst for 2 cycles, all outputs 0. Then load with load_val=5, start, and apply 5 tick pulses.
  - remaining steps 5,4,3,2,1,0.
  - done=1 and expire=1 for one cycle on the 5th tick.
  - running=0 after that.
- Pause and resume: preset=10, 3 ticks, pause, 4 ticks, start, 7 ticks.
  - remaining holds 7 during the pause.
  - Expiry occurs exactly on the final tick.
  - A tick coincident with pause at remaining=1 still expires to DONE.
- Auto-reload: auto_reload=1, preset=3, 9 ticks.
  - expire pulses on ticks 3, 6 and 9.
  - remaining sequence is 2,1,3,2,1,3,...
  - done stays 0.
- Clear and priority:
  - In RUN at remaining=4, assert clear+load+start in the same cycle: state=IDLE, remaining=preset, load is ignored.
  - start with preset=0 stays IDLE.
- Tick robustness: hold tick_ms high for 5 cycles: one decrement only.
- Reset mid-run: assert rst at remaining=2 in RUN: all outputs 0 next cycle, and later ticks are ignored.
